// File: rtl/ram_bank_ctrl.sv
// Frame controller for ram_bank: writes one frame of MEM_HEIGHT words at ascending addresses, then reads it
// back through a 2-entry output buffer. Define RAM_CTRL_REVERSE_EN to drain the frame in reverse order.
module ram_bank_ctrl #(
  parameter int ADDR_BIT   = 3,
  parameter int DATA_BIT   = 16,
  parameter int MEM_HEIGHT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_BIT-1:0] s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_BIT-1:0] m_data,
  output logic                ram_en,
  output logic                ram_we,
  output logic                ram_re,
  output logic [ADDR_BIT-1:0] ram_addr_w,
  output logic [DATA_BIT-1:0] ram_d_w,
  output logic [ADDR_BIT-1:0] ram_addr_r,
  input  logic [DATA_BIT-1:0] ram_d_r,
  output logic                busy,
  output logic                frame_done
);

  localparam int CNT_W = ADDR_BIT + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_HEIGHT - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MEM_HEIGHT);

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_s_ready;
  logic                r_frame_done;
  logic [CNT_W-1:0]    r_wr_cnt;
  logic [CNT_W-1:0]    r_rd_cnt;
  logic [CNT_W-1:0]    r_pop_cnt;
  logic                r_inflight;
  logic [DATA_BIT-1:0] r_buf [2];
  logic                r_buf_wr_ptr;
  logic                r_buf_rd_ptr;
  logic [1:0]          r_buf_occ;

  logic                w_wr_fire;
  logic                w_rd_fire;
  logic                w_pop;
  logic                w_last_pop;
  logic [2:0]          w_pending;
  logic [ADDR_BIT-1:0] w_rd_addr;

  // Both streams transfer a word on any cycle where valid and ready are high together; valid never waits on
  // ready, and m_data/m_valid stay put while the consumer holds m_ready low.
  assign w_wr_fire  = s_valid & r_s_ready & (r_state == ST_FILL);
  assign w_pop      = (r_buf_occ != 2'd0) & m_ready;
  assign w_last_pop = w_pop & (r_pop_cnt == LAST);

  // Words already buffered plus the one returning from the bank, less the one leaving this cycle.
  assign w_pending = {1'b0, r_buf_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_fire = (r_state == ST_DRAIN) & (r_rd_cnt < FULL) & (w_pending < 3'd2);

`ifdef RAM_CTRL_REVERSE_EN
  logic [CNT_W-1:0] w_rd_rev;
  assign w_rd_rev  = LAST - r_rd_cnt;
  assign w_rd_addr = w_rd_rev[ADDR_BIT-1:0];
`else
  assign w_rd_addr = r_rd_cnt[ADDR_BIT-1:0];
`endif

  assign ram_we     = w_wr_fire;
  assign ram_re     = w_rd_fire;
  assign ram_en     = w_wr_fire | w_rd_fire;
  assign ram_addr_w = w_wr_fire ? r_wr_cnt[ADDR_BIT-1:0] : '0;
  assign ram_d_w    = w_wr_fire ? s_data : '0;
  assign ram_addr_r = w_rd_fire ? w_rd_addr : '0;

  assign s_ready    = r_s_ready;
  assign busy       = (r_state == ST_DRAIN);
  assign frame_done = r_frame_done;
  assign m_valid    = (r_buf_occ != 2'd0);
  assign m_data     = r_buf[r_buf_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_FILL;
      r_s_ready    <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_pop_cnt    <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_FILL: begin
          r_s_ready <= 1'b1;
          if (w_wr_fire) begin
            if (r_wr_cnt == LAST) begin
              r_wr_cnt  <= '0;
              r_s_ready <= 1'b0;
              r_state   <= ST_DRAIN;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_rd_fire) r_rd_cnt <= r_rd_cnt + 1'b1;
          if (w_pop) r_pop_cnt <= r_pop_cnt + 1'b1;
          if (w_last_pop) begin
            r_state      <= ST_FILL;
            r_rd_cnt     <= '0;
            r_pop_cnt    <= '0;
            r_s_ready    <= 1'b1;
            r_frame_done <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_FILL;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  // The bank answers one cycle after the read is issued; the word lands in the slot the head is not using.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf[0]     <= '0;
      r_buf[1]     <= '0;
      r_buf_wr_ptr <= 1'b0;
      r_buf_rd_ptr <= 1'b0;
      r_buf_occ    <= 2'd0;
      r_inflight   <= 1'b0;
    end else begin
      r_inflight <= w_rd_fire;
      if (r_inflight) begin
        r_buf[r_buf_wr_ptr] <= ram_d_r;
        r_buf_wr_ptr        <= ~r_buf_wr_ptr;
      end
      if (w_pop) r_buf_rd_ptr <= ~r_buf_rd_ptr;
      r_buf_occ <= w_pending[1:0];
    end
  end

endmodule

// File: doc/ram_bank_ctrl.md
# ram_bank_ctrl

Frame controller sitting directly upstream of `ram_bank`: accepts a valid/ready input stream, writes one frame of `MEM_HEIGHT` words into the bank at sequential addresses, then reads the frame back and emits it on a valid/ready output stream. It owns all `ram_bank` control pins (`en`, `we`, `re`, `addr_w`, `d_w`, `addr_r`) and consumes `d_r`, hiding the bank's one-cycle read latency behind a 2-entry output buffer.

## Interface
- `ADDR_BIT`, 3, bank address width
- `DATA_BIT`, 16, word width
- `MEM_HEIGHT`, 8, words per frame; 2 ≤ `MEM_HEIGHT` ≤ 2^`ADDR_BIT`
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `s_valid`  in  1  input word valid
- `s_ready`  out  1  controller accepts input word
- `s_data`  in  DATA_BIT  input word
- `m_valid`  out  1  output word valid
- `m_ready`  in  1  downstream accepts output word
- `m_data`  out  DATA_BIT  output word
- `ram_en`, `ram_we`, `ram_re`  out  1 each  to bank `en`, `we`, `re`
- `ram_addr_w`  out  ADDR_BIT  to bank `addr_w`
- `ram_d_w`  out  DATA_BIT  to bank `d_w`
- `ram_addr_r`  out  ADDR_BIT  to bank `addr_r`
- `ram_d_r`  in  DATA_BIT  from bank `d_r`
- `busy`  out  1  high in DRAIN
- `frame_done`  out  1  one-cycle pulse after last word of a frame is popped

## Operation
- FSM states: FILL, DRAIN. Reset state FILL.
- FILL: `s_ready`=1 (0 while `rst_n`=0). On `s_valid & s_ready`: `ram_we`=1, `ram_addr_w`=wr_cnt, `ram_d_w`=`s_data`, same cycle (combinational). wr_cnt increments 0..MEM_HEIGHT-1. The handshake writing address MEM_HEIGHT-1 moves state to DRAIN; wr_cnt returns to 0.
- DRAIN: `s_ready`=0, `busy`=1. Read issued (`ram_re`=1, `ram_addr_r`=rd_addr) when fewer than MEM_HEIGHT reads issued and (buffer occupancy + reads in flight − pop this cycle) < 2. Returned `ram_d_r` captured into buffer on the edge after the issue cycle.
- `ram_en` = `ram_we | ram_re`. `ram_we` and `ram_re` never both high.
- Buffer: 2-entry FIFO; `m_valid` = not empty; `m_data` = head; pop on `m_valid & m_ready`. No word lost or duplicated under any `m_ready` pattern.
- On pop of word MEM_HEIGHT-1 (count, not address): `frame_done`=1 next cycle, state → FILL, rd counters cleared. `s_ready` returns to 1 the cycle after that pop.
- Counters are ADDR_BIT+1 bits; never wrap within a frame.
- Reset mid-operation: state, counters, buffer, in-flight flag cleared immediately; partial frame discarded; bank contents not cleared (not required).

## Timing
- Reset values: `s_ready`=0 during reset, 1 after; `m_valid`=0, `m_data`=0, all `ram_*` outputs 0, `busy`=0, `frame_done`=0.
- Bank model: write on rising edge with `en & we`; `d_r` valid the cycle after `addr_r` sampled with `en & re`.
- Write latency: word written at the edge ending its handshake cycle.
- Drain latency: first read issued in the first DRAIN cycle; first `m_valid` two cycles later.
- Throughput: 1 word/cycle in both states with `s_valid`=1 / `m_ready`=1 held; frame turnaround = MEM_HEIGHT + MEM_HEIGHT + 2 cycles minimum.
- `m_data` stable while `m_valid & !m_ready`.

## Configuration
- `RAM_CTRL_REVERSE_EN` defined: drain addresses MEM_HEIGHT-1 down to 0 (frame emitted reversed, LIFO).
- Not defined: drain addresses 0 up to MEM_HEIGHT-1 (frame emitted in arrival order, FIFO).
- Write order is ascending in both builds.

## Test plan
- Reset: hold `rst_n`=0 50 ns → all outputs at reset values, `s_ready`=0; release → `s_ready`=1 next cycle.
- Full-rate frame: push 0..7 with `s_valid`=1, `m_ready`=1 → `ram_addr_w`/`ram_d_w` = 0..7 on 8 consecutive cycles; `m_data` = 0..7 (7..0 with `RAM_CTRL_REVERSE_EN`) on 8 consecutive cycles, first 2 cycles after DRAIN entry; `frame_done` pulses once.
- Backpressure: during drain toggle `m_ready` 1,0,0,1,0,1… → output sequence still exactly 0..7, `m_data` held while stalled, `ram_re` never issues a read with buffer+inflight ≥ 2.
- Input gaps: `s_valid` pattern 1,0,1,1,0… → only handshake cycles write; addresses contiguous 0..7; `s_ready`=0 throughout DRAIN even with `s_valid`=1.
- Reset mid-drain after 3 words popped → outputs return to reset values immediately; next frame 0x10..0x17 drains as 0x10..0x17 with no stale words.
- Back-to-back frames 0..7 then 8..15 → second frame accepted one cycle after first `frame_done`-triggering pop; output 0..15 in frame order.
